vertex_feeder: RTL and testbench

- Initiator that streams a vertex list from vertex memory through the start/done transform unit (the 4x4 matrix multiply with perspective divide), then writes the transformed vertices to an output buffer.
- Sits between the vertex RAM and the transform unit, and is driven by the frame controller via go/finished.
- Each vertex is 3 consecutive 32-bit fp words: x, y, z.

---
 rtl/gfx_pkg.sv | 19 +
 rtl/feeder_capture.sv | 52 +++++
 rtl/vertex_feeder.sv | 233 +++++++++++++++++++++++
 tb/tb_vertex_feeder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared types and constants for the vertex feeder
package gfx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_LAUNCH,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_WRITE,
        ST_FINISH
    } feeder_state_t;

    localparam logic [31:0] FP_ONE        = 32'h3f800000;
    localparam int          WORDS_PER_VTX = 3;
    localparam logic [1:0]  LAST_WORD     = 2'(WORDS_PER_VTX - 1);

endpackage

// File: rtl/feeder_capture.sv
// rtl/feeder_capture.sv - delays read strobes by the RAM latency and names the x/y/z capture cycles
module feeder_capture
    import gfx_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic flush,
    input  logic rd_en,
    output logic cap_x,
    output logic cap_y,
    output logic cap_z
);

    logic [MEM_LAT-1:0] en_pipe;
    logic [1:0]         word_idx;
    logic               data_valid;

    assign data_valid = en_pipe[MEM_LAT-1];

    // Track each read strobe down to the cycle its data appears on rd_data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_pipe <= '0;
        end else begin
            en_pipe[0] <= rd_en;
            for (int i = 1; i < MEM_LAT; i++) begin
                en_pipe[i] <= en_pipe[i-1];
            end
        end
    end

    // Count returning words so each one lands in the right operand; idle clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx <= '0;
        end else if (flush) begin
            word_idx <= '0;
        end else if (data_valid) begin
            word_idx <= (word_idx == LAST_WORD) ? 2'd0 : word_idx + 2'd1;
        end
    end

    // Decode the word index into one strobe per operand
    always_comb begin
        cap_x = data_valid && (word_idx == 2'd0);
        cap_y = data_valid && (word_idx == 2'd1);
        cap_z = data_valid && (word_idx == 2'd2);
    end

endmodule

// File: rtl/vertex_feeder.sv
// rtl/vertex_feeder.sv - streams vertices from RAM through the transform unit into the output buffer
module vertex_feeder
    import gfx_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int CNT_W   = 10,
    parameter int MEM_LAT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  vtx_count,
    output logic              busy,
    output logic              finished,
    output logic              error,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              xf_start,
    output logic [31:0]       xf_x,
    output logic [31:0]       xf_y,
    output logic [31:0]       xf_z,
    input  logic              xf_done,
    input  logic [31:0]       xf_x_out,
    input  logic [31:0]       xf_y_out,
    input  logic [31:0]       xf_z_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    feeder_state_t      state;
    feeder_state_t      state_nxt;
    logic [ADDR_W-1:0]  src_ptr;
    logic [ADDR_W-1:0]  dst_ptr;
    logic [CNT_W-1:0]   remaining;
    logic [1:0]         word_idx;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [31:0]        res_x;
    logic [31:0]        res_y;
    logic [31:0]        res_z;
    logic               last_word;
    logic               waiting;
    logic               wait_expired;
    logic               timeout_hit;
    logic               cap_x;
    logic               cap_y;
    logic               cap_z;

    assign last_word    = (word_idx == LAST_WORD);
    assign waiting      = (state == ST_LAUNCH) || (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    feeder_capture #(
        .MEM_LAT (MEM_LAT)
    ) u_capture (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (state == ST_IDLE),
        .rd_en   (rd_en),
        .cap_x   (cap_x),
        .cap_y   (cap_y),
        .cap_z   (cap_z)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a wait state that sits out its full budget aborts the run
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nxt = (vtx_count == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (last_word) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cap_z) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (xf_done) begin
                    state_nxt = ST_WAIT_LOW;
                end else if (wait_expired) begin
                    state_nxt   = ST_FINISH;
                    timeout_hit = 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                if (!xf_done) begin
                    state_nxt = ST_WAIT_HIGH;
                end else if (wait_expired) begin
                    state_nxt   = ST_FINISH;
                    timeout_hit = 1'b1;
                end
            end
            ST_WAIT_HIGH: begin
                if (xf_done) begin
                    state_nxt = ST_WRITE;
                end else if (wait_expired) begin
                    state_nxt   = ST_FINISH;
                    timeout_hit = 1'b1;
                end
            end
            ST_WRITE: begin
                if (last_word) begin
                    state_nxt = (remaining == CNT_W'(1)) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; addresses and data are forced to zero when not strobed
    always_comb begin
        busy     = (state != ST_IDLE);
        finished = (state == ST_FINISH);
        rd_en    = (state == ST_FETCH);
        rd_addr  = '0;
        xf_start = (state == ST_LAUNCH) && xf_done;
        wr_en    = (state == ST_WRITE);
        wr_addr  = '0;
        wr_data  = '0;
        if (rd_en) begin
            rd_addr = src_ptr + ADDR_W'(word_idx);
        end
        if (wr_en) begin
            wr_addr = dst_ptr + ADDR_W'(word_idx);
            case (word_idx)
                2'd0:    wr_data = res_x;
                2'd1:    wr_data = res_y;
                default: wr_data = res_z;
            endcase
        end
    end

    // Word index walks 0..2 during the fetch and write bursts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx <= '0;
        end else if (((state == ST_FETCH) || (state == ST_WRITE)) && !last_word) begin
            word_idx <= word_idx + 2'd1;
        end else begin
            word_idx <= '0;
        end
    end

    // Wait counter restarts on every state change and only runs in the handshake states
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!waiting || (state_nxt != state)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Run bookkeeping: latch the job on go, advance per vertex, keep the sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            error     <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && go) begin
                src_ptr   <= src_base;
                dst_ptr   <= dst_base;
                remaining <= vtx_count;
                error     <= 1'b0;
            end else if ((state == ST_WRITE) && last_word) begin
                src_ptr   <= src_ptr + ADDR_W'(WORDS_PER_VTX);
                dst_ptr   <= dst_ptr + ADDR_W'(WORDS_PER_VTX);
                remaining <= remaining - CNT_W'(1);
            end
            if (timeout_hit) begin
                error <= 1'b1;
            end
        end
    end

    // Operands load only on their capture strobe, so they stay put while the transform runs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xf_x <= '0;
            xf_y <= '0;
            xf_z <= '0;
        end else begin
            if (cap_x) xf_x <= rd_data;
            if (cap_y) xf_y <= rd_data;
            if (cap_z) xf_z <= rd_data;
        end
    end

    // Results are taken on the done edge that ends the transform
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_x <= '0;
            res_y <= '0;
            res_z <= '0;
        end else if ((state == ST_WAIT_HIGH) && xf_done) begin
            res_x <= xf_x_out;
            res_y <= xf_y_out;
            res_z <= xf_z_out;
        end
    end

endmodule

// File: tb/tb_vertex_feeder.sv
// tb/tb_vertex_feeder.sv - self-checking bench for vertex_feeder
module tb_vertex_feeder;
    import gfx_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int CNT_W   = 10;
    localparam int MEM_LAT = 2;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [CNT_W-1:0]  cnt;
        int                words;
        logic [ADDR_W-1:0] rd_first;
        logic [ADDR_W-1:0] rd_last;
        logic [ADDR_W-1:0] wa_first;
        logic [ADDR_W-1:0] wa_last;
        logic [31:0]       wd_first;
        logic [31:0]       wd_last;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              go = 1'b0;
    logic [ADDR_W-1:0] src_base = '0;
    logic [ADDR_W-1:0] dst_base = '0;
    logic [CNT_W-1:0]  vtx_count = '0;
    logic              busy, finished, error, rd_en, xf_start, wr_en, xf_done;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [31:0]       rd_data, xf_x, xf_y, xf_z, wr_data;
    logic [31:0]       xf_x_out, xf_y_out, xf_z_out;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vertex_feeder #(
        .ADDR_W (ADDR_W), .CNT_W (CNT_W), .MEM_LAT (MEM_LAT), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .reset_n (reset_n), .go (go),
        .src_base (src_base), .dst_base (dst_base), .vtx_count (vtx_count),
        .busy (busy), .finished (finished), .error (error),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
        .xf_start (xf_start), .xf_x (xf_x), .xf_y (xf_y), .xf_z (xf_z),
        .xf_done (xf_done), .xf_x_out (xf_x_out), .xf_y_out (xf_y_out), .xf_z_out (xf_z_out),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data)
    );

    // Vertex RAM with a fixed MEM_LAT read pipeline
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] rd_pipe [0:MEM_LAT-1];
    always @(posedge clk) begin
        rd_pipe[0] <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data = rd_pipe[MEM_LAT-1];

    // Identity transform: done drops after start, operands sampled 2 cycles in, done returns after 6
    logic        stuck = 1'b0;
    int          ph = 0;
    logic [31:0] rx = '0, ry = '0, rz = '0;
    always @(posedge clk) begin
        if (xf_start && xf_done && !stuck) begin
            ph <= 1;
        end else if (ph != 0) begin
            if (ph == 2) begin
                rx <= xf_x; ry <= xf_y; rz <= xf_z;
            end
            ph <= (ph == 6) ? 0 : ph + 1;
        end
    end
    assign xf_done  = (ph == 0);
    assign xf_x_out = rx;
    assign xf_y_out = ry;
    assign xf_z_out = rz;

    // Activity monitor
    int                cyc = 0;
    logic [ADDR_W-1:0] rd_q[$];
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int n_start, n_bad_start, n_fin, fin_cyc, last_wr_cyc, start_cyc, err_cyc;
    bit err_seen;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_q.push_back(rd_addr);
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            last_wr_cyc = cyc;
        end
        if (xf_start) begin
            n_start++;
            start_cyc = cyc;
            if (!xf_done) n_bad_start++;
        end
        if (finished) begin
            n_fin++;
            fin_cyc = cyc;
        end
        if (error && !err_seen) begin
            err_seen = 1'b1;
            err_cyc  = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete(); wa_q.delete(); wd_q.delete();
        n_start = 0; n_bad_start = 0; n_fin = 0; err_seen = 1'b0;
        fin_cyc = -1; last_wr_cyc = -1; start_cyc = -1; err_cyc = -1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, 64'({busy, finished, error, rd_en, xf_start, wr_en}), 64'd0);
        check({tag, "_addr"}, 64'({rd_addr, wr_addr}), 64'd0);
        check({tag, "_wdata"}, 64'(wr_data), 64'd0);
        check({tag, "_ops"}, 64'(xf_x | xf_y | xf_z), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit poke_go);
        int  go_cyc;
        int  bad;
        bit  got;
        @(negedge clk);
        clear_logs();
        src_base = v.src; dst_base = v.dst; vtx_count = v.cnt; go = 1'b1;
        @(posedge clk);
        go_cyc = cyc;
        #1 go = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            go = 1'b0;
            if (poke_go && i == 8) begin
                src_base = 10'h3FE; dst_base = 10'h000; vtx_count = '0; go = 1'b1;
            end
            if (n_fin > 0) got = 1'b1;
        end
        go = 1'b0;
        check("fin_seen", 64'(got), 64'd1);
        check("idle_after_fin", 64'({busy, finished}), 64'd0);
        repeat (3) @(negedge clk);
        check("fin_once", 64'(n_fin), 64'd1);
        check("run_error", 64'(error), 64'd0);
        check("rd_count", 64'(rd_q.size()), 64'(v.words));
        check("wr_count", 64'(wa_q.size()), 64'(v.words));
        check("start_count", 64'(n_start), 64'(v.cnt));
        check("start_while_busy", 64'(n_bad_start), 64'd0);
        if (v.cnt == 0) check("fin_gap_go", 64'(fin_cyc - go_cyc), 64'd1);
        else            check("fin_gap_wr", 64'(fin_cyc - last_wr_cyc), 64'd1);
        bad = 0;
        for (int k = 0; k < v.words && k < rd_q.size(); k++)
            if (rd_q[k] !== ADDR_W'(v.src + k)) bad++;
        for (int k = 0; k < v.words && k < wa_q.size(); k++) begin
            if (wa_q[k] !== ADDR_W'(v.dst + k)) bad++;
            if (wd_q[k] !== mem[ADDR_W'(v.src + k)]) bad++;
        end
        check("seq_mismatches", 64'(bad), 64'd0);
        if (v.words > 0 && rd_q.size() > 0 && wa_q.size() > 0) begin
            check("rd_first", 64'(rd_q[0]), 64'(v.rd_first));
            check("rd_last", 64'(rd_q[rd_q.size()-1]), 64'(v.rd_last));
            check("wa_first", 64'(wa_q[0]), 64'(v.wa_first));
            check("wa_last", 64'(wa_q[wa_q.size()-1]), 64'(v.wa_last));
            check("wd_first", 64'(wd_q[0]), 64'(v.wd_first));
            check("wd_last", 64'(wd_q[wd_q.size()-1]), 64'(v.wd_last));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        bit   got;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[10'h010] = FP_ONE;
        mem[10'h011] = 32'h4000_0000;
        mem[10'h012] = 32'h4040_0000;

        vecs[0] = '{10'h010, 10'h200, 10'd1, 3, 10'h010, 10'h012, 10'h200, 10'h202, 32'h3f80_0000, 32'h4040_0000};
        vecs[1] = '{10'h020, 10'h100, 10'd4, 12, 10'h020, 10'h02B, 10'h100, 10'h10B, 32'hA500_0020, 32'hA500_002B};
        vecs[2] = '{10'h3FE, 10'h3FF, 10'd1, 3, 10'h3FE, 10'h000, 10'h3FF, 10'h001, 32'hA500_03FE, 32'hA500_0000};
        vecs[3] = '{10'h000, 10'h050, 10'd0, 0, 10'h000, 10'h000, 10'h000, 10'h000, 32'h0, 32'h0};

        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0);

        // Transform never drops done: abort 64 cycles into WAIT_LOW, no writes
        stuck = 1'b1;
        @(negedge clk);
        clear_logs();
        src_base = 10'h020; dst_base = 10'h180; vtx_count = 10'd1; go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (n_fin > 0) got = 1'b1;
        end
        check("to_fin_seen", 64'(got), 64'd1);
        check("to_start_count", 64'(n_start), 64'd1);
        check("to_err_delay", 64'(err_cyc - start_cyc), 64'd65);
        check("to_fin_delay", 64'(fin_cyc - start_cyc), 64'd65);
        repeat (4) @(negedge clk);
        check("to_no_write", 64'(wa_q.size()), 64'd0);
        check("to_error_sticky", 64'({error, busy}), 64'b10);
        stuck = 1'b0;
        vtx_count = '0; go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        check("go_clears_error", 64'({error, finished}), 64'b01);
        repeat (3) @(negedge clk);

        // Async reset while waiting for the transform result
        clear_logs();
        src_base = 10'h040; dst_base = 10'h1C0; vtx_count = 10'd1; go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (n_start > 0) got = 1'b1;
        end
        check("rst_start_seen", 64'(got), 64'd1);
        @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_zero("midrun_reset");
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_reads", 64'(rd_q.size()), 64'd3);
        check("rst_no_write", 64'(wa_q.size()), 64'd0);
        check("rst_no_finish", 64'(n_fin), 64'd0);
        repeat (10) @(negedge clk);

        // go pulsed while busy must be ignored, then a plain run after reset
        run_vec('{10'h030, 10'h140, 10'd2, 6, 10'h030, 10'h035, 10'h140, 10'h145, 32'hA500_0030, 32'hA500_0035}, 1'b1);
        run_vec('{10'h060, 10'h2F0, 10'd1, 3, 10'h060, 10'h062, 10'h2F0, 10'h2F2, 32'hA500_0060, 32'hA500_0062}, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
